// File: rtl/rvm_seq_adder.sv
// Multi-cycle add/subtract/compare unit, CHUNK bits per clock, LSB first.
// Define RVM_SEQ_ADDER_CMP_EN to build GE/GEU/LT/LTU; otherwise those ops complete as undefined.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// BUSY  | processing one chunk per cycle
// DONE  | response held on rsp_* until rsp_ready
module rvm_seq_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_lhs,
  input  logic [WIDTH-1:0] req_rhs,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_GE  = 3'b011;
  localparam logic [2:0] OP_GEU = 3'b100;
  localparam logic [2:0] OP_LT  = 3'b101;
  localparam logic [2:0] OP_LTU = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  lhs_q, rhs_q, res_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              chain_q;
  logic              carry_q, ovf_q;

  logic              accept;
  logic              inv;
  int                lo;
  logic [CHUNK-1:0]  a_chunk, b_chunk;
  logic [CHUNK:0]    sum_full;
  logic              chunk_ovf;
  logic              cmp_bit;

  // Ops that need the BUSY pass; everything else completes in one cycle with zero result.
  function automatic logic is_arith(input logic [2:0] op);
`ifdef RVM_SEQ_ADDER_CMP_EN
    return (op >= OP_ADD) && (op <= OP_LTU);
`else
    return (op == OP_ADD) || (op == OP_SUB);
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = is_arith(req_op) ? S_BUSY : S_DONE;
      S_BUSY: if (cnt_q == LAST) state_d = S_DONE;
      S_DONE: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE) && !reset;
    rsp_valid = (state_q == S_DONE) && !reset;
  end

  assign accept       = req_valid && req_ready;
  assign rsp_result   = res_q;
  assign rsp_carry    = carry_q;
  assign rsp_overflow = ovf_q;

  always_comb begin
    inv       = (op_q != OP_ADD);
    lo        = int'(cnt_q) * CHUNK;
    a_chunk   = lhs_q[lo +: CHUNK];
    b_chunk   = rhs_q[lo +: CHUNK] ^ {CHUNK{inv}};
    sum_full  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, chain_q};
    chunk_ovf = (a_chunk[CHUNK-1] == b_chunk[CHUNK-1]) &&
                (sum_full[CHUNK-1] != a_chunk[CHUNK-1]);
    cmp_bit   = 1'b0;
`ifdef RVM_SEQ_ADDER_CMP_EN
    case (op_q)
      OP_GE:   cmp_bit = !(sum_full[CHUNK-1] ^ chunk_ovf);
      OP_GEU:  cmp_bit = sum_full[CHUNK];
      OP_LT:   cmp_bit = sum_full[CHUNK-1] ^ chunk_ovf;
      OP_LTU:  cmp_bit = !sum_full[CHUNK];
      default: cmp_bit = 1'b0;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      lhs_q   <= '0;
      rhs_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      chain_q <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q    <= req_op;
            lhs_q   <= req_lhs;
            rhs_q   <= req_rhs;
            cnt_q   <= '0;
            chain_q <= (req_op != OP_ADD);
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        S_BUSY: begin
          res_q[lo +: CHUNK] <= sum_full[CHUNK-1:0];
          chain_q            <= sum_full[CHUNK];
          cnt_q              <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
              carry_q <= sum_full[CHUNK];
              ovf_q   <= chunk_ovf;
            end else begin
              // Compare ops replace the partial difference with the 1-bit verdict.
              res_q <= {{(WIDTH-1){1'b0}}, cmp_bit};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
